// File: rtl/multi_light_aim_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aim_pkg (package)
// Description : Shared types and constants for the multi-light aim calculator:
//               FSM state encoding, divider length, pan quadrant size, tilt
//               scaling shift and DMX address width, plus an 8-bit saturator.
// Revision    : 1.0 - initial release
// ============================================================================
package aim_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DIV   = 3'd2,
        S_ANGLE = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    localparam int DIV_CYCLES   = 9;   // one cycle per quotient bit
    localparam int PAN_QUADRANT = 64;  // pan steps per 90 degrees
    localparam int TILT_SHIFT   = 4;
    localparam int DMX_ADDR_W   = 9;

    // Clamp an unsigned value into 0..255.
    function automatic logic [7:0] sat_u8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_light_aim_calc_div.sv
`default_nettype none
// ============================================================================
// Module      : seq_ratio_div
// Description : Restoring divider producing ratio = (num << 8) / den with nine
//               quotient bits, saturated to 255. den = 0 yields 0. The first
//               quotient bit is resolved in the start cycle directly from the
//               num/den inputs, the remaining eight in the following cycles.
//               Callers guarantee num <= den, so nine bits cover the result.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start           - load operands and resolve quotient bit 8
//               num, den        - W-bit unsigned operands
//               busy            - high while quotient bits remain
//               valid           - one-cycle strobe when q is final
//               q[7:0]          - saturated ratio, held until next start
// Revision    : 1.0 - initial release
// ============================================================================
module seq_ratio_div
    import aim_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         busy,
    output logic         valid,
    output logic [7:0]   q
);

    logic [W-1:0] r_den;
    logic [W-1:0] r_rem;
    logic [8:0]   r_quo;
    logic [3:0]   r_cnt;
    logic         r_den_zero;

    // First step compares the unshifted numerator (quotient weight 2^8).
    logic         w_ge0;
    logic [W-1:0] w_rem0;
    assign w_ge0  = (num >= den);
    assign w_rem0 = w_ge0 ? (num - den) : num;

    // Remainder is always below den, so the shifted value needs one extra
    // bit for the compare but the difference always fits back into W bits.
    logic [W:0]   w_shift;
    logic         w_ge;
    logic [W-1:0] w_rem_nx;
    assign w_shift  = {r_rem, 1'b0};
    assign w_ge     = (w_shift >= {1'b0, r_den});
    assign w_rem_nx = w_ge ? (w_shift[W-1:0] - r_den) : w_shift[W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_den      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_den_zero <= 1'b0;
            busy       <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                r_den      <= den;
                r_den_zero <= (den == '0);
                r_rem      <= w_rem0;
                r_quo      <= {8'd0, w_ge0};
                r_cnt      <= 4'd1;
                busy       <= 1'b1;
            end else if (busy) begin
                r_rem <= w_rem_nx;
                r_quo <= {r_quo[7:0], w_ge};
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'(DIV_CYCLES - 1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

    // num == den gives exactly 256, which saturates.
    assign q = r_den_zero ? 8'd0 : (r_quo[8] ? 8'hFF : r_quo[7:0]);

endmodule
`default_nettype wire

// File: rtl/multi_light_aim_calc.sv
`default_nettype none
// ============================================================================
// Module      : multi_light_aim_calc
// Description : Computes pan/tilt aim values and DMX channel addresses for
//               NUM_LIGHTS fixtures from one latched camera centre-of-mass
//               sample. Lights are processed one after another through a
//               shared sequential ratio divider, 12 cycles per light:
//               LOAD, 9 x DIV, ANGLE, EMIT.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               start                   - begin a pass (accepted in IDLE only)
//               x_com, y_com            - target position, latched on start
//               light_x/light_y         - packed fixture positions
//               light_base_addr         - packed 9-bit DMX pan channels
//               busy                    - pass in progress
//               out_valid, light_idx    - per-light result strobe and index
//               pan, tilt               - aim values
//               pan_addr, tilt_addr     - DMX channels for the result
//               done                    - strobe with the last out_valid
// Config      : AIM_SMOOTH_EN - per-light first-order smoothing of pan/tilt
// Revision    : 1.0 - initial release
// ============================================================================
module multi_light_aim_calc
    import aim_pkg::*;
#(
    parameter  int NUM_LIGHTS     = 4,
    parameter  int XW             = 11,
    parameter  int YW             = 10,
    parameter  int TILT_GAIN      = 4,
    parameter  int TILT_CH_OFFSET = 1,
    localparam int IW             = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [XW-1:0]                    x_com,
    input  logic [YW-1:0]                    y_com,
    input  logic [NUM_LIGHTS*XW-1:0]         light_x,
    input  logic [NUM_LIGHTS*YW-1:0]         light_y,
    input  logic [NUM_LIGHTS*DMX_ADDR_W-1:0] light_base_addr,
    output logic                             busy,
    output logic                             out_valid,
    output logic [IW-1:0]                    light_idx,
    output logic [7:0]                       pan,
    output logic [7:0]                       tilt,
    output logic [DMX_ADDR_W-1:0]            pan_addr,
    output logic [DMX_ADDR_W-1:0]            tilt_addr,
    output logic                             done
);

    // Absolute deltas carry one extra bit so the divider sees full ranges.
    localparam int AW = ((XW > YW) ? XW : YW) + 1;

    state_t r_state, w_state_nx;

    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [IW-1:0]         r_idx;
    logic [1:0]            r_quad;
    logic                  r_b_le_a;
    logic                  r_zero;
    logic [AW:0]           r_r;
    logic [DMX_ADDR_W-1:0] r_base;
    logic [7:0]            r_ratio;

    logic w_last;
    assign w_last = (r_idx == IW'(NUM_LIGHTS - 1));

    // ------------------------------------------------------------------
    // LOAD: geometry of the current light
    // ------------------------------------------------------------------
    logic [XW-1:0]         w_lx;
    logic [YW-1:0]         w_ly;
    logic [DMX_ADDR_W-1:0] w_base;
    assign w_lx   = light_x[int'(r_idx)*XW +: XW];
    assign w_ly   = light_y[int'(r_idx)*YW +: YW];
    assign w_base = light_base_addr[int'(r_idx)*DMX_ADDR_W +: DMX_ADDR_W];

    logic signed [XW:0] w_dx;
    logic signed [YW:0] w_dy;
    logic [XW:0]        w_ax;
    logic [YW:0]        w_ay;
    assign w_dx = $signed({1'b0, r_x}) - $signed({1'b0, w_lx});
    assign w_dy = $signed({1'b0, r_y}) - $signed({1'b0, w_ly});
    assign w_ax = w_dx[XW] ? (~$unsigned(w_dx) + 1'b1) : $unsigned(w_dx);
    assign w_ay = w_dy[YW] ? (~$unsigned(w_dy) + 1'b1) : $unsigned(w_dy);

    logic [1:0]    w_quad;
    logic [AW-1:0] w_a, w_b, w_num, w_den;
    logic          w_b_le_a;
    assign w_quad   = w_dx[XW] ? (w_dy[YW] ? 2'd2 : 2'd1)
                               : (w_dy[YW] ? 2'd3 : 2'd0);
    // Odd quadrants swap axes so the angle always increases with the ratio.
    assign w_a      = w_quad[0] ? AW'(w_ay) : AW'(w_ax);
    assign w_b      = w_quad[0] ? AW'(w_ax) : AW'(w_ay);
    assign w_b_le_a = (w_b <= w_a);
    assign w_num    = w_b_le_a ? w_b : w_a;
    assign w_den    = w_b_le_a ? w_a : w_b;

    // ------------------------------------------------------------------
    // Shared divider
    // ------------------------------------------------------------------
    logic       div_busy, div_valid;
    logic [7:0] div_q;

    seq_ratio_div #(
        .W (AW)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (r_state == S_LOAD),
        .num   (w_num),
        .den   (w_den),
        .busy  (div_busy),
        .valid (div_valid),
        .q     (div_q)
    );

    // ------------------------------------------------------------------
    // ANGLE: pan from quadrant + octant ratio, tilt from distance estimate
    // ------------------------------------------------------------------
    logic [6:0]  w_sub;
    logic [7:0]  w_pan_raw;
    logic [31:0] w_tilt_prod;
    logic [7:0]  w_tilt_raw;
    logic [7:0]  w_pan_out;
    logic [7:0]  w_tilt_out;

    assign w_sub       = r_b_le_a ? 7'(r_ratio >> 3)
                                  : 7'(PAN_QUADRANT) - 7'(r_ratio >> 3);
    assign w_pan_raw   = r_zero ? 8'd0
                                : 8'(int'(r_quad) * PAN_QUADRANT + int'(w_sub));
    assign w_tilt_prod = 32'(r_r) * 32'(TILT_GAIN);
    assign w_tilt_raw  = sat_u8(w_tilt_prod >> TILT_SHIFT);

`ifdef AIM_SMOOTH_EN
    logic [7:0]            r_prev_pan  [NUM_LIGHTS];
    logic [7:0]            r_prev_tilt [NUM_LIGHTS];
    logic [NUM_LIGHTS-1:0] r_seeded;

    // Pan difference wraps in 8 bits so the step follows the short arc.
    logic [7:0]        w_dpan;
    logic signed [7:0] w_pan_step;
    logic signed [8:0] w_dtilt;
    logic signed [8:0] w_tilt_step;
    assign w_dpan      = w_pan_raw - r_prev_pan[r_idx];
    assign w_pan_step  = $signed(w_dpan) >>> 2;
    assign w_dtilt     = $signed({1'b0, w_tilt_raw}) - $signed({1'b0, r_prev_tilt[r_idx]});
    assign w_tilt_step = w_dtilt >>> 2;

    assign w_pan_out  = r_seeded[r_idx] ? (r_prev_pan[r_idx] + $unsigned(w_pan_step))
                                        : w_pan_raw;
    assign w_tilt_out = r_seeded[r_idx]
                      ? 8'($signed({1'b0, r_prev_tilt[r_idx]}) + w_tilt_step)
                      : w_tilt_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seeded <= '0;
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                r_prev_pan[i]  <= 8'd0;
                r_prev_tilt[i] <= 8'd0;
            end
        end else if (r_state == S_ANGLE) begin
            r_prev_pan[r_idx]  <= w_pan_out;
            r_prev_tilt[r_idx] <= w_tilt_out;
            r_seeded[r_idx]    <= 1'b1;
        end
    end
`else
    assign w_pan_out  = w_pan_raw;
    assign w_tilt_out = w_tilt_raw;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nx = S_LOAD;
            S_LOAD:  w_state_nx = S_DIV;
            S_DIV:   if (!div_busy) w_state_nx = S_ANGLE;
            S_ANGLE: w_state_nx = S_EMIT;
            S_EMIT:  w_state_nx = w_last ? S_IDLE : S_LOAD;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_idx     <= '0;
            r_quad    <= '0;
            r_b_le_a  <= 1'b0;
            r_zero    <= 1'b0;
            r_r       <= '0;
            r_base    <= '0;
            r_ratio   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            light_idx <= '0;
            pan       <= '0;
            tilt      <= '0;
            pan_addr  <= '0;
            tilt_addr <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x   <= x_com;
                        r_y   <= y_com;
                        r_idx <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_quad   <= w_quad;
                    r_b_le_a <= w_b_le_a;
                    r_zero   <= (w_ax == '0) && (w_ay == '0);
                    // max(ax,ay) + min(ax,ay)/2
                    r_r      <= (AW+1)'(w_den) + (AW+1)'(w_num >> 1);
                    r_base   <= w_base;
                end
                S_DIV: begin
                    if (div_valid) r_ratio <= div_q;
                end
                S_ANGLE: begin
                    pan       <= w_pan_out;
                    tilt      <= w_tilt_out;
                    pan_addr  <= r_base;
                    tilt_addr <= r_base + DMX_ADDR_W'(TILT_CH_OFFSET);
                    light_idx <= r_idx;
                    out_valid <= 1'b1;
                    done      <= w_last;
                    busy      <= ~w_last;
                end
                S_EMIT: begin
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_light_aim_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_light_aim_calc
// Description : Self-checking bench for multi_light_aim_calc (default build,
//               AIM_SMOOTH_EN undefined). A table of directed aim vectors,
//               hand-written start-while-busy and mid-pass reset sequences,
//               and randomized passes are compared against an arithmetic
//               reference model of the aiming rules.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multi_light_aim_calc;

    localparam int NL = 4;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int AWD = 9;
    localparam int IW = 2;
    localparam int TGAIN = 4;
    localparam int TOFS = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [XW-1:0]   x_com;
    logic [YW-1:0]   y_com;
    logic [NL*XW-1:0]  light_x;
    logic [NL*YW-1:0]  light_y;
    logic [NL*AWD-1:0] light_base_addr;
    logic            busy, out_valid, done;
    logic [IW-1:0]   light_idx;
    logic [7:0]      pan, tilt;
    logic [AWD-1:0]  pan_addr, tilt_addr;

    always #5 clk = ~clk;

    multi_light_aim_calc #(
        .NUM_LIGHTS     (NL),
        .XW             (XW),
        .YW             (YW),
        .TILT_GAIN      (TGAIN),
        .TILT_CH_OFFSET (TOFS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .x_com           (x_com),
        .y_com           (y_com),
        .light_x         (light_x),
        .light_y         (light_y),
        .light_base_addr (light_base_addr),
        .busy            (busy),
        .out_valid       (out_valid),
        .light_idx       (light_idx),
        .pan             (pan),
        .tilt            (tilt),
        .pan_addr        (pan_addr),
        .tilt_addr       (tilt_addr),
        .done            (done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Aiming rules evaluated directly with integer arithmetic.
    function automatic void model(input int x, input int y, input int lx, input int ly,
                                  output int e_pan, output int e_tilt);
        int dx, dy, ax, ay, q, a, b, num, den, ratio, sub, r;
        dx = x - lx;
        dy = y - ly;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        if (dx >= 0 && dy >= 0)     q = 0;
        else if (dx < 0 && dy >= 0) q = 1;
        else if (dx < 0)            q = 2;
        else                        q = 3;
        if (q == 0 || q == 2) begin a = ax; b = ay; end
        else                  begin a = ay; b = ax; end
        num = (a < b) ? a : b;
        den = (a < b) ? b : a;
        ratio = (den == 0) ? 0 : (num * 256) / den;
        if (ratio > 255) ratio = 255;
        sub = (b <= a) ? ratio / 8 : 64 - ratio / 8;
        e_pan = (q * 64 + sub) % 256;
        if (dx == 0 && dy == 0) e_pan = 0;
        r = ((ax > ay) ? ax : ay) + ((ax > ay) ? ay : ax) / 2;
        e_tilt = (r * TGAIN) / 16;
        if (e_tilt > 255) e_tilt = 255;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_light(input int i, input int lx, input int ly, input int base);
        light_x[i*XW +: XW]           = XW'(lx);
        light_y[i*YW +: YW]           = YW'(ly);
        light_base_addr[i*AWD +: AWD] = AWD'(base);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_pan"},       pan, 0);
        check({tag, "_tilt"},      tilt, 0);
        check({tag, "_pan_addr"},  pan_addr, 0);
        check({tag, "_tilt_addr"}, tilt_addr, 0);
        check({tag, "_light_idx"}, light_idx, 0);
    endtask

    // One pass: start in cycle 0, optional second start and reset pulses,
    // 60 cycles observed. Strobe i must be at cycle 12+12i.
    task automatic run_pass(input int extra_start, input int rst_at, input int exp_count,
                            output int p0, output int t0, output int taddr3);
        int ep[NL];
        int et[NL];
        int base[NL];
        int got;
        p0 = -1; t0 = -1; taddr3 = -1;
        for (int i = 0; i < NL; i++) begin
            model(int'(x_com), int'(y_com), int'(light_x[i*XW +: XW]),
                  int'(light_y[i*YW +: YW]), ep[i], et[i]);
            base[i] = int'(light_base_addr[i*AWD +: AWD]);
        end
        start = 1'b1;
        got = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick();
            start = (cyc == extra_start);
            reset = (cyc == rst_at);
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                // Latched copies must be used from here on.
                x_com = XW'($urandom);
                y_com = YW'($urandom);
            end
            if (rst_at > 0 && cyc == rst_at + 1)
                check_outputs_zero("after_reset");
            if (out_valid) begin
                if (got < NL) begin
                    check($sformatf("strobe_cycle[%0d]", got), cyc, 12 + 12 * got);
                    check($sformatf("light_idx[%0d]", got), light_idx, got);
                    check($sformatf("pan[%0d]", got), pan, ep[got]);
                    check($sformatf("tilt[%0d]", got), tilt, et[got]);
                    check($sformatf("pan_addr[%0d]", got), pan_addr, base[got]);
                    check($sformatf("tilt_addr[%0d]", got), tilt_addr, (base[got] + TOFS) % 512);
                    check($sformatf("done[%0d]", got), done, (got == NL - 1) ? 1 : 0);
                    check($sformatf("busy_at_strobe[%0d]", got), busy, (got == NL - 1) ? 0 : 1);
                    if (got == 0) begin p0 = pan; t0 = tilt; end
                    if (got == NL - 1) taddr3 = tilt_addr;
                end
                got++;
            end else if (got > 0 && got <= NL && cyc == 12 * got + 1) begin
                check($sformatf("hold_pan[%0d]", got - 1), pan, ep[got - 1]);
                check($sformatf("hold_tilt[%0d]", got - 1), tilt, et[got - 1]);
                check($sformatf("done_low[%0d]", got - 1), done, 0);
            end
        end
        check("strobe_count", got, exp_count);
        start = 1'b0;
        reset = 1'b0;
    endtask

    typedef struct {
        string name;
        int    x;
        int    y;
        int    pan;
        int    tilt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p0, t0, ta3;
        int lx, ly;

        vecs[0] = '{"same",  200,  400,   0,   0};
        vecs[1] = '{"east",  300,  400,   0,  25};
        vecs[2] = '{"ne",    300,  500,  31,  37};
        vecs[3] = '{"west",  100,  400, 128,  25};
        vecs[4] = '{"south", 200,  300, 192,  25};
        vecs[5] = '{"sat",  2047,  400,   0, 255};
        vecs[6] = '{"sw",    100,  300, 159,  37};

        reset = 1'b1;
        start = 1'b0;
        x_com = '0;
        y_com = '0;
        light_x = '0;
        light_y = '0;
        light_base_addr = '0;
        repeat (3) tick();
        check_outputs_zero("in_reset");
        reset = 1'b0;
        tick();
        check_outputs_zero("post_reset");

        set_light(0, 200, 400, 1);
        set_light(1, 0, 0, 10);
        set_light(2, 2047, 1023, 20);
        set_light(3, 1000, 500, 511);

        // Directed vectors on light 0; other lights checked against the model.
        for (int v = 0; v < 7; v++) begin
            x_com = XW'(vecs[v].x);
            y_com = YW'(vecs[v].y);
            run_pass(-1, -1, NL, p0, t0, ta3);
            check({"table_pan_", vecs[v].name}, p0, vecs[v].pan);
            check({"table_tilt_", vecs[v].name}, t0, vecs[v].tilt);
            if (v == 0) check("tilt_addr_wrap", ta3, 0);
            tick();
        end

        // Start while busy is ignored.
        x_com = XW'(300);
        y_com = YW'(500);
        run_pass(20, -1, NL, p0, t0, ta3);
        check("busy_start_ignored_pan0", p0, 31);
        tick();

        // Reset mid-pass: only lights 0 and 1 emerge, then a fresh pass.
        x_com = XW'(300);
        y_com = YW'(400);
        run_pass(-1, 30, 2, p0, t0, ta3);
        x_com = XW'(100);
        y_com = YW'(400);
        run_pass(-1, -1, NL, p0, t0, ta3);
        check("after_reset_pass_pan0", p0, 128);
        tick();

        // Randomized passes.
        for (int n = 0; n < 16; n++) begin
            x_com = XW'($urandom);
            y_com = YW'($urandom);
            for (int i = 0; i < NL; i++) begin
                lx = int'($urandom_range(0, 2047));
                ly = int'($urandom_range(0, 1023));
                if ($urandom_range(0, 7) == 0) lx = int'(x_com);
                if ($urandom_range(0, 7) == 0) ly = int'(y_com);
                set_light(i, lx, ly, int'($urandom_range(0, 511)));
            end
            run_pass(-1, -1, NL, p0, t0, ta3);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
